disp_page_sched: RTL and testbench

- Scheduler that shares the 16-bit, 4-digit seven-segment display path (disp_data into the display scan register) between four CPU debug sources: PC, ALU result, register file word and data-memory word.
- Selects the active page either by auto-rotation or by a manual button pulse.
- Fetches register-file and memory words over a req/ack debug read port.
- Updates disp_data atomically so the display never shows torn values.

---
 rtl/disp_pkg.sv | 20 ++
 rtl/disp_page_ctr.sv | 49 ++++
 rtl/disp_page_sched.sv | 137 +++++++++++++
 tb/tb_disp_page_sched.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared encodings for the display page scheduler: page numbers, FSM states
// and the pattern shown when a remote read times out.
package disp_pkg;

    typedef enum logic [1:0] {
        PAGE_PC  = 2'd0,
        PAGE_ALU = 2'd1,
        PAGE_RF  = 2'd2,
        PAGE_MEM = 2'd3
    } page_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    localparam logic [31:0] STALE_PATTERN = 32'hDEAD_DEAD;

endpackage

// File: rtl/disp_page_ctr.sv
// Page register with auto-rotation dwell counter and manual button advance.
// page_changed_o is high in the cycle whose closing edge moves the page.
module disp_page_ctr
    import disp_pkg::*;
#(
    parameter int DWELL_TICKS = 512
) (
    input  logic  clk,
    input  logic  clr,
    input  logic  tick_i,
    input  logic  mode_auto_i,
    input  logic  btn_next_i,
    output page_e page_o,
    output logic  page_changed_o
);

    localparam int CW = (DWELL_TICKS > 2) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL_TICKS - 1);

    logic          mode_q;
    logic [CW-1:0] dwell_q;
    page_e         page_q;
    logic          mode_chg, wrap, adv;

    // A mode flip restarts the dwell count, so that cycle's tick is not counted.
    assign mode_chg = (mode_auto_i != mode_q);
    assign wrap     = mode_auto_i && !mode_chg && tick_i && (dwell_q == LAST);
    assign adv      = wrap || (!mode_auto_i && btn_next_i);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mode_q  <= 1'b0;
            dwell_q <= '0;
            page_q  <= PAGE_PC;
        end else begin
            mode_q <= mode_auto_i;
            if (mode_chg || wrap)
                dwell_q <= '0;
            else if (mode_auto_i && tick_i)
                dwell_q <= dwell_q + 1'b1;
            if (adv)
                page_q <= page_e'(page_q + 2'd1);
        end
    end

    assign page_o         = page_q;
    assign page_changed_o = adv;

endmodule

// File: rtl/disp_page_sched.sv
// Shares the 16-bit display path between PC, ALU, register-file and memory
// pages; remote words are fetched over the debug req/ack port.
module disp_page_sched
    import disp_pkg::*;
#(
    parameter int DWELL_TICKS = 512,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        tick,
    input  logic        mode_auto,
    input  logic        btn_next,
    input  logic        half_sel,
    input  logic [7:0]  sel_addr,
    input  logic [31:0] pc,
    input  logic [31:0] alu_result,
    output logic        dbg_req,
    output logic        dbg_sel,
    output logic [31:0] dbg_addr,
    input  logic        dbg_ack,
    input  logic [31:0] dbg_rdata,
    output logic [15:0] disp_data,
    output logic [1:0]  page,
    output logic        stale
);

    localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(ACK_TIMEOUT - 1);

    page_e         cur_page;
    logic          page_chg;
    state_e        state_q;
    logic          pending_q, pending_d, abort_q, trig;
    logic          half_sel_q;
    logic [7:0]    sel_addr_q;
    logic [TW-1:0] tmo_q;
    logic [31:0]   buf_q, dbg_addr_q;
    logic          dbg_req_q, dbg_sel_q, stale_q;
    logic [15:0]   disp_q;

    disp_page_ctr #(.DWELL_TICKS(DWELL_TICKS)) u_ctr (
        .clk            (clk),
        .clr            (clr),
        .tick_i         (tick),
        .mode_auto_i    (mode_auto),
        .btn_next_i     (btn_next),
        .page_o         (cur_page),
        .page_changed_o (page_chg)
    );

    // New triggers win over the IDLE consume so a request arriving that cycle is kept.
    assign trig      = tick || page_chg || (half_sel != half_sel_q) || (sel_addr != sel_addr_q);
    assign pending_d = trig || (pending_q && (state_q != ST_IDLE));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b0;
            abort_q    <= 1'b0;
            half_sel_q <= 1'b0;
            sel_addr_q <= '0;
            tmo_q      <= '0;
            buf_q      <= '0;
            dbg_addr_q <= '0;
            dbg_req_q  <= 1'b0;
            dbg_sel_q  <= 1'b0;
            stale_q    <= 1'b0;
            disp_q     <= '0;
        end else begin
            half_sel_q <= half_sel;
            sel_addr_q <= sel_addr;
            pending_q  <= pending_d;
            if (page_chg && state_q == ST_WAIT)
                abort_q <= 1'b1;
            case (state_q)
                ST_IDLE: if (pending_q) begin
                    case (cur_page)
                        PAGE_PC: begin
                            buf_q   <= pc;
                            state_q <= ST_LATCH;
                        end
                        PAGE_ALU: begin
                            buf_q   <= alu_result;
                            state_q <= ST_LATCH;
                        end
                        PAGE_RF: begin
                            dbg_sel_q  <= 1'b0;
                            dbg_addr_q <= {27'b0, sel_addr[4:0]};
                            dbg_req_q  <= 1'b1;
                            tmo_q      <= '0;
                            state_q    <= ST_WAIT;
                        end
                        PAGE_MEM: begin
                            dbg_sel_q  <= 1'b1;
                            dbg_addr_q <= {22'b0, sel_addr, 2'b00};
                            dbg_req_q  <= 1'b1;
                            tmo_q      <= '0;
                            state_q    <= ST_WAIT;
                        end
                    endcase
                end
                ST_WAIT: begin
                    if (dbg_ack) begin
                        buf_q     <= dbg_rdata;
                        stale_q   <= 1'b0;
                        dbg_req_q <= 1'b0;
                        state_q   <= ST_LATCH;
                    end else if (tmo_q == TLAST) begin
                        buf_q     <= STALE_PATTERN;
                        stale_q   <= 1'b1;
                        dbg_req_q <= 1'b0;
                        state_q   <= ST_LATCH;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_LATCH: begin
                    // An aborted fetch belongs to the old page; its pending refresh redraws.
                    if (!abort_q)
                        disp_q <= half_sel ? buf_q[31:16] : buf_q[15:0];
                    abort_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dbg_req   = dbg_req_q;
    assign dbg_sel   = dbg_sel_q;
    assign dbg_addr  = dbg_addr_q;
    assign disp_data = disp_q;
    assign page      = cur_page;
    assign stale     = stale_q;

endmodule

// File: tb/tb_disp_page_sched.sv
// Self-checking bench for disp_page_sched: scenario tasks plus a randomized
// run checked against a page/word model of the display.
module tb_disp_page_sched;
    localparam int DW = 4;
    localparam int AT = 8;

    logic        clk = 1'b0;
    logic        clr, tick, mode_auto, btn_next, half_sel;
    logic [7:0]  sel_addr;
    logic [31:0] pc, alu_result;
    logic        dbg_req, dbg_sel, dbg_ack;
    logic [31:0] dbg_addr, dbg_rdata;
    logic [15:0] disp_data;
    logic [1:0]  page;
    logic        stale;

    logic        ack_r = 1'b0, late_ack = 1'b0;
    logic [31:0] rdata_r = '0;
    int          checks = 0, errors = 0;
    int          ack_delay = 0, wcnt = 0, req_count = 0;
    bit          resp_en = 1'b1, ovr_en = 1'b0;
    logic [31:0] ovr_data = '0;
    logic [31:0] rf [32];
    logic [31:0] dm [256];
    int          exp_page = 0;

    assign dbg_ack   = ack_r | late_ack;
    assign dbg_rdata = late_ack ? 32'hCAFE_F00D : rdata_r;

    always #5 clk = ~clk;

    disp_page_sched #(.DWELL_TICKS(DW), .ACK_TIMEOUT(AT)) dut (
        .clk(clk), .clr(clr), .tick(tick), .mode_auto(mode_auto), .btn_next(btn_next),
        .half_sel(half_sel), .sel_addr(sel_addr), .pc(pc), .alu_result(alu_result),
        .dbg_req(dbg_req), .dbg_sel(dbg_sel), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack),
        .dbg_rdata(dbg_rdata), .disp_data(disp_data), .page(page), .stale(stale)
    );

    // Debug-port responder: acks ack_delay cycles after dbg_req rises.
    always @(posedge clk) begin
        #1;
        ack_r = 1'b0;
        if (dbg_req) begin
            if (wcnt == 0) req_count++;
            if (resp_en && wcnt == ack_delay) begin
                ack_r   = 1'b1;
                rdata_r = ovr_en ? ovr_data : (dbg_sel ? dm[dbg_addr[9:2]] : rf[dbg_addr[4:0]]);
            end
            wcnt++;
        end else begin
            wcnt = 0;
        end
    end

    function automatic logic [15:0] exp_disp(int pg, logic h, logic [7:0] a);
        logic [31:0] w;
        case (pg)
            0:       w = pc;
            1:       w = alu_result;
            2:       w = rf[a[4:0]];
            default: w = dm[a];
        endcase
        return h ? w[31:16] : w[15:0];
    endfunction

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit t, input bit b);
        @(posedge clk); #1 tick = t; btn_next = b;
        @(posedge clk); #1 tick = 1'b0; btn_next = 1'b0;
    endtask

    task automatic wait_req(input bit level, output bit ok);
        int n = 0;
        while (dbg_req !== level && n < 40) begin @(negedge clk); n++; end
        ok = (dbg_req === level);
    endtask

    task automatic test_reset();
        clr = 1'b1; tick = 1'b1; btn_next = 1'b1; mode_auto = 1'b1; half_sel = 1'b1;
        sel_addr = 8'hFF; pc = 32'hFFFF_FFFF; alu_result = '0; late_ack = 1'b1;
        cyc(3);
        checks++;
        if (disp_data !== 16'h0 || page !== 2'd0 || dbg_req !== 1'b0 || stale !== 1'b0 ||
            dbg_sel !== 1'b0 || dbg_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset: disp=%h page=%0d req=%b stale=%b sel=%b addr=%h, want all zero",
                     disp_data, page, dbg_req, stale, dbg_sel, dbg_addr);
        end
        tick = 1'b0; btn_next = 1'b0; mode_auto = 1'b0; half_sel = 1'b0; sel_addr = '0;
        late_ack = 1'b0; pc = 32'h0040_1a9b;
        cyc(1); clr = 1'b0;
        cyc(2);
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (disp_data !== 16'h0) begin
            errors++; $display("FAIL local_latency_early: disp=%h want 0000", disp_data);
        end
        @(posedge clk); #1;
        checks++;
        if (disp_data !== 16'h1a9b) begin
            errors++; $display("FAIL local_latency: disp=%h want 1a9b", disp_data);
        end
    endtask

    task automatic test_auto();
        mode_auto = 1'b1; ack_delay = 0;
        cyc(2);
        for (int k = 1; k <= 16; k++) begin
            pulse(1'b1, 1'b0);
            cyc(1);
            @(negedge clk);
            checks++;
            if (page !== 2'((k / DW) % 4)) begin
                errors++; $display("FAIL auto_page tick %0d: page=%0d want %0d", k, page, (k / DW) % 4);
            end
        end
        for (int k = 0; k < DW - 1; k++) begin pulse(1'b1, 1'b0); cyc(1); end
        pulse(1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (page !== 2'd1) begin
            errors++; $display("FAIL wrap_plus_btn: page=%0d want 1", page);
        end
        pulse(1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (page !== 2'd1) begin
            errors++; $display("FAIL btn_in_auto: page=%0d want 1", page);
        end
        mode_auto = 1'b0; exp_page = 1;
        cyc(3);
    endtask

    task automatic test_rf();
        bit ok;
        int hi, ack_at;
        logic [31:0] a0;
        logic s0;
        bit unstable;
        pulse(1'b0, 1'b1); exp_page = 2;
        cyc(20);
        rf[5] = 32'h1234_5678; ack_delay = 3;
        @(posedge clk); #1 half_sel = 1'b1; sel_addr = 8'h05;
        wait_req(1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rf_req_rise: req=%b want 1", dbg_req); end
        a0 = dbg_addr; s0 = dbg_sel; hi = 0; ack_at = -1; unstable = 0;
        while (dbg_req && hi < 40) begin
            if (dbg_addr !== a0 || dbg_sel !== s0) unstable = 1;
            if (dbg_ack) ack_at = hi;
            hi++;
            @(negedge clk);
        end
        checks++;
        if (a0 !== 32'd5 || s0 !== 1'b0 || unstable) begin
            errors++; $display("FAIL rf_addr: addr=%h sel=%b unstable=%0d want 00000005 0 0", a0, s0, unstable);
        end
        checks++;
        if (hi != 4 || ack_at != 3) begin
            errors++; $display("FAIL rf_req_len: high=%0d ack_at=%0d want 4 3", hi, ack_at);
        end
        @(negedge clk);
        checks++;
        if (disp_data !== 16'h1234 || stale !== 1'b0) begin
            errors++; $display("FAIL rf_disp: disp=%h stale=%b want 1234 0", disp_data, stale);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int hi;
        pulse(1'b0, 1'b1); exp_page = 3;
        cyc(20);
        resp_en = 1'b0;
        @(posedge clk); #1 sel_addr = 8'h10;
        wait_req(1'b1, ok);
        checks++;
        if (!ok || dbg_addr !== 32'h40 || dbg_sel !== 1'b1) begin
            errors++; $display("FAIL mem_addr: req=%b addr=%h sel=%b want 1 00000040 1", dbg_req, dbg_addr, dbg_sel);
        end
        hi = 0;
        while (dbg_req && hi < 40) begin hi++; @(negedge clk); end
        checks++;
        if (hi != AT || stale !== 1'b1) begin
            errors++; $display("FAIL timeout_len: high=%0d stale=%b want %0d 1", hi, stale, AT);
        end
        @(negedge clk);
        checks++;
        if (disp_data !== 16'hDEAD) begin
            errors++; $display("FAIL timeout_disp: disp=%h want dead", disp_data);
        end
        resp_en = 1'b1; ack_delay = 1;
        pulse(1'b1, 1'b0);
        cyc(15);
        checks++;
        if (stale !== 1'b0 || disp_data !== dm[8'h10][31:16]) begin
            errors++; $display("FAIL stale_clear: stale=%b disp=%h want 0 %h", stale, disp_data, dm[8'h10][31:16]);
        end
    endtask

    task automatic test_abort_coalesce();
        bit ok;
        int base;
        logic [15:0] prev;
        for (int i = 0; i < 3; i++) begin pulse(1'b0, 1'b1); cyc(12); end
        exp_page = 2;
        prev = disp_data;
        ovr_en = 1'b1; ovr_data = 32'hFFFF_FFFF; ack_delay = 6;
        pulse(1'b1, 1'b0);
        wait_req(1'b1, ok);
        pulse(1'b0, 1'b1); exp_page = 3;
        wait_req(1'b0, ok);
        @(negedge clk);
        checks++;
        if (!ok || disp_data !== prev) begin
            errors++; $display("FAIL abort_hold: disp=%h want %h", disp_data, prev);
        end
        ovr_en = 1'b0;
        cyc(25);
        checks++;
        if (page !== 2'd3 || disp_data !== exp_disp(3, half_sel, sel_addr)) begin
            errors++; $display("FAIL abort_refresh: page=%0d disp=%h want 3 %h", page, disp_data, exp_disp(3, half_sel, sel_addr));
        end
        base = req_count;
        pulse(1'b1, 1'b0);
        wait_req(1'b1, ok);
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
        cyc(30);
        checks++;
        if (req_count - base != 2) begin
            errors++; $display("FAIL coalesce: requests=%0d want 2", req_count - base);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        resp_en = 1'b0;
        pulse(1'b1, 1'b0);
        wait_req(1'b1, ok);
        #1 clr = 1'b1;
        #1;
        checks++;
        if (!ok || dbg_req !== 1'b0 || page !== 2'd0 || disp_data !== 16'h0) begin
            errors++; $display("FAIL async_clr: seen=%0d req=%b page=%0d disp=%h want 1 0 0 0000", ok, dbg_req, page, disp_data);
        end
        sel_addr = '0; half_sel = 1'b0; tick = 1'b0; btn_next = 1'b0;
        #1 clr = 1'b0; exp_page = 0;
        @(posedge clk); #1 late_ack = 1'b1;
        cyc(2); late_ack = 1'b0;
        cyc(5);
        checks++;
        if (dbg_req !== 1'b0 || disp_data !== 16'h0 || stale !== 1'b0) begin
            errors++; $display("FAIL late_ack: req=%b disp=%h stale=%b want 0 0000 0", dbg_req, disp_data, stale);
        end
        resp_en = 1'b1;
    endtask

    task automatic test_random();
        int nb;
        for (int it = 0; it < 12; it++) begin
            nb = $urandom_range(0, 3);
            for (int b = 0; b < nb; b++) begin pulse(1'b0, 1'b1); cyc(1); end
            exp_page = (exp_page + nb) % 4;
            cyc(12);
            half_sel = 1'($urandom); sel_addr = 8'($urandom);
            pc = $urandom; alu_result = $urandom; ack_delay = $urandom_range(0, 5);
            pulse(1'b1, 1'b0);
            cyc(25);
            checks++;
            if (page !== 2'(exp_page) || disp_data !== exp_disp(exp_page, half_sel, sel_addr)) begin
                errors++;
                $display("FAIL random %0d: page=%0d disp=%h want %0d %h", it, page, disp_data,
                         exp_page, exp_disp(exp_page, half_sel, sel_addr));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++)  rf[i] = $urandom;
        for (int i = 0; i < 256; i++) dm[i] = $urandom;
        test_reset();
        test_auto();
        test_rf();
        test_timeout();
        test_abort_coalesce();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
